// File: rtl/ones_frame_accumulator_pkg.sv
// Shared types and constants for the ones-count frame accumulator.
// Provides the FSM state type, byte/popcount widths and the byte parity helper.
package ones_pkg;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} ones_state_t;

  localparam int POP_W  = 4;
  localparam int BYTE_W = 8;

  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ones_frame_accumulator_popcount8.sv
// Combinational population count of one byte (0..8 set bits).
module popcount8
  import ones_pkg::*;
(
  input  logic [BYTE_W-1:0] data,
  output logic [POP_W-1:0]  count
);

  // Sum the individual bits of the byte
  always_comb begin
    count = {POP_W{1'b0}};
    for (int i = 0; i < BYTE_W; i++) begin
      count = count + {{(POP_W-1){1'b0}}, data[i]};
    end
  end

endmodule

// File: rtl/ones_frame_accumulator.sv
// Accumulates set bits and byte count per in_last-delimited frame; saturating counters.
// Optional frame parity output is enabled with the ONES_PARITY_EN macro.
module ones_frame_accumulator
  import ones_pkg::*;
#(
  parameter int CNT_W = 12,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [LEN_W-1:0]  out_bytes,
`ifdef ONES_PARITY_EN
  output logic              out_parity,
`endif
  output logic              out_overflow
);

  ones_state_t      state_r;
  logic [CNT_W-1:0] acc_cnt_r;
  logic [LEN_W-1:0] acc_len_r;
  logic             acc_ovf_r;
  logic [POP_W-1:0] pop_s;
  logic [CNT_W:0]   cnt_sum_s;
  logic [LEN_W:0]   len_sum_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic [LEN_W-1:0] len_next_s;
  logic             ovf_next_s;
  logic             accept_s;

  popcount8 u_popcount8 (
    .data  (in_data),
    .count (pop_s)
  );

  assign in_ready = (state_r == ACCUM);
  assign accept_s = in_valid & in_ready;

  // Next accumulator values including the current byte, clamped at all-ones
  always_comb begin
    cnt_sum_s = {1'b0, acc_cnt_r} + {{(CNT_W+1-POP_W){1'b0}}, pop_s};
    len_sum_s = {1'b0, acc_len_r} + {{LEN_W{1'b0}}, 1'b1};
    if (cnt_sum_s[CNT_W]) begin
      cnt_next_s = {CNT_W{1'b1}};
    end else begin
      cnt_next_s = cnt_sum_s[CNT_W-1:0];
    end
    if (len_sum_s[LEN_W]) begin
      len_next_s = {LEN_W{1'b1}};
    end else begin
      len_next_s = len_sum_s[LEN_W-1:0];
    end
    ovf_next_s = acc_ovf_r | cnt_sum_s[CNT_W] | len_sum_s[LEN_W];
  end

  // Frame FSM, accumulators and registered result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ACCUM;
      acc_cnt_r    <= {CNT_W{1'b0}};
      acc_len_r    <= {LEN_W{1'b0}};
      acc_ovf_r    <= 1'b0;
      out_valid    <= 1'b0;
      out_count    <= {CNT_W{1'b0}};
      out_bytes    <= {LEN_W{1'b0}};
      out_overflow <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s && in_last) begin
            out_count    <= cnt_next_s;
            out_bytes    <= len_next_s;
            out_overflow <= ovf_next_s;
            out_valid    <= 1'b1;
            acc_cnt_r    <= {CNT_W{1'b0}};
            acc_len_r    <= {LEN_W{1'b0}};
            acc_ovf_r    <= 1'b0;
            state_r      <= HOLD;
          end else if (accept_s) begin
            acc_cnt_r <= cnt_next_s;
            acc_len_r <= len_next_s;
            acc_ovf_r <= ovf_next_s;
          end else begin
            acc_cnt_r <= acc_cnt_r;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ACCUM;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= ACCUM;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ONES_PARITY_EN
  logic acc_par_r;

  // Running XOR of all accepted frame bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_par_r  <= 1'b0;
      out_parity <= 1'b0;
    end else if (accept_s && in_last) begin
      out_parity <= acc_par_r ^ byte_parity(in_data);
      acc_par_r  <= 1'b0;
    end else if (accept_s) begin
      acc_par_r <= acc_par_r ^ byte_parity(in_data);
    end else begin
      acc_par_r <= acc_par_r;
    end
  end
`endif

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Self-checking bench: directed frames plus random frames against a queue-based model.
module tb_ones_frame_accumulator;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_count;
  logic [7:0]  out_bytes;
  logic        out_overflow;
`ifdef ONES_PARITY_EN
  logic        out_parity;
`endif

  int errors = 0;
  int checks = 0;

  ones_frame_accumulator dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_count    (out_count),
    .out_bytes    (out_bytes),
`ifdef ONES_PARITY_EN
    .out_parity   (out_parity),
`endif
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: frame totals from plain arithmetic over the whole byte list
  function automatic void model(input bq_t q, output int cnt, output int len,
                                output bit ovf, output bit par);
    int total = 0;
    par = 1'b0;
    foreach (q[i]) begin
      total += $countones(q[i]);
      par ^= ^q[i];
    end
    cnt = (total > 4095) ? 4095 : total;
    len = (q.size() > 255) ? 255 : q.size();
    ovf = (total > 4095) || (q.size() > 255);
  endfunction

  task automatic send_frame(input string tag, input bq_t q, input bit gaps);
    int cnt, len, k;
    bit ovf, par;
    model(q, cnt, len, ovf, par);
    foreach (q[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom_range(0, 255));
          in_last  = 1'($urandom_range(0, 1));
          tick();
        end
      end
      k = 0;
      while (!in_ready && k < 50) begin
        tick();
        k++;
      end
      if (i == 0 || gaps) chk({tag, "_in_ready"}, in_ready, 1);
      if (i == 0) chk({tag, "_valid_pre"}, out_valid, 0);
      in_valid = 1'b1;
      in_data  = q[i];
      in_last  = (i == q.size() - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_out_count"}, out_count, cnt);
    chk({tag, "_out_bytes"}, out_bytes, len);
    chk({tag, "_out_overflow"}, out_overflow, ovf);
`ifdef ONES_PARITY_EN
    chk({tag, "_out_parity"}, out_parity, par);
`endif
  endtask

  // Keep the result pending for some cycles with junk on the input, then take it
  task automatic drain(input string tag, input int hold);
    logic [11:0] c;
    logic [7:0]  b;
    logic        o;
    c = out_count;
    b = out_bytes;
    o = out_overflow;
    out_ready = 1'b0;
    repeat (hold) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 255));
      in_last  = 1'b1;
      tick();
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_ready"}, in_ready, 0);
      chk({tag, "_hold_count"}, out_count, c);
      chk({tag, "_hold_bytes"}, out_bytes, b);
      chk({tag, "_hold_ovf"}, out_overflow, o);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, out_valid, 0);
    chk({tag, "_drain_ready"}, in_ready, 1);
  endtask

  initial begin
    bq_t q;

    // Reset state
    reset = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_bytes", out_bytes, 0);
    chk("rst_out_overflow", out_overflow, 0);
`ifdef ONES_PARITY_EN
    chk("rst_out_parity", out_parity, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Basic three-byte frame
    q = '{8'hFF, 8'h0F, 8'h01};
    send_frame("t1", q, 1'b0);
    chk("t1_count13", out_count, 13);
    drain("t1", 0);

    // Single zero byte
    q = '{8'h00};
    send_frame("t2", q, 1'b0);
    chk("t2_bytes1", out_bytes, 1);
    // Long backpressure on the result
    drain("t3", 5);

    // Byte counter saturation
    q = {};
    repeat (256) q.push_back(8'hFF);
    send_frame("t4", q, 1'b0);
    chk("t4_count2048", out_count, 2048);
    chk("t4_bytes255", out_bytes, 255);
    chk("t4_ovf", out_overflow, 1);
    drain("t4", 1);

    // Ones counter saturation
    q = {};
    repeat (600) q.push_back(8'hFF);
    send_frame("tsat", q, 1'b0);
    chk("tsat_count4095", out_count, 4095);
    drain("tsat", 0);

    // Reset mid-frame discards the partial frame
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #2;
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    q = '{8'h03};
    send_frame("t5", q, 1'b0);
    chk("t5_count2", out_count, 2);
    chk("t5_bytes1", out_bytes, 1);

    // Reset while a result is pending
    #2 reset = 1'b1;
    #2;
    chk("thold_rst_valid", out_valid, 0);
    chk("thold_rst_count", out_count, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

`ifdef ONES_PARITY_EN
    q = '{8'h07, 8'h01};
    send_frame("t6a", q, 1'b0);
    chk("t6a_count4", out_count, 4);
    chk("t6a_par0", out_parity, 0);
    drain("t6a", 0);
    q = '{8'h07};
    send_frame("t6b", q, 1'b0);
    chk("t6b_par1", out_parity, 1);
    drain("t6b", 0);
`endif

    // Random frames with input gaps and random result backpressure
    for (int f = 0; f < 25; f++) begin
      q = {};
      repeat ($urandom_range(1, 40)) q.push_back(8'($urandom_range(0, 255)));
      send_frame("rnd", q, 1'b1);
      drain("rnd", $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
